// File: rtl/eth_task_sched.sv
// eth_task_sched: shares the eth_task SPI engine between two requesters and CPU buffer-RAM access.
// Define ETH_SCHED_TIMEOUT_EN to build the eth_done timeout counter and the reqN_err flags.
module eth_task_sched #(
  parameter int START_LEN = 6,
  parameter int TIMEOUT   = 65535,
  parameter int ADDR_W    = 24,
  parameter int SIZE_W    = 13
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [SIZE_W-1:0] req0_size,
  output logic              req0_ack,
  output logic              req0_err,
  input  logic              req1,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [SIZE_W-1:0] req1_size,
  output logic              req1_ack,
  output logic              req1_err,
  input  logic              mb_req,
  output logic              mb_gnt,
  output logic              eth_start,
  output logic [ADDR_W-1:0] eth_addr,
  output logic [SIZE_W-1:0] eth_size,
  output logic              eth_ram_sel,
  input  logic              eth_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT, ACK, CPU} state_t;

  state_t     state;
  logic [1:0] ptr;        // last served source: 0 = req0, 1 = req1, 2 = CPU
  logic       owner;      // SPI requester of the transaction in flight
  logic [3:0] start_cnt;
  logic       done_d;
  logic       done_rise;
  logic [1:0] grant;
  logic       grant_vld;

  assign done_rise = eth_done & ~done_d;

`ifdef ETH_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;

  assign to_hit = (to_cnt == 16'(TIMEOUT - 1));
`else
  // Without the timeout counter TIMEOUT has no consumer; the errors are constant.
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign req0_err       = 1'b0;
  assign req1_err       = 1'b0;
`endif

  // Round-robin: the first asserted source after ptr wins, wrapping 0 -> 1 -> 2 -> 0.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    grant     = 2'd0;
    grant_vld = 1'b1;
    case (ptr)
      2'd0: begin
        if (req1)        grant = 2'd1;
        else if (mb_req) grant = 2'd2;
        else if (req0)   grant = 2'd0;
        else             grant_vld = 1'b0;
      end
      2'd1: begin
        if (mb_req)      grant = 2'd2;
        else if (req0)   grant = 2'd0;
        else if (req1)   grant = 2'd1;
        else             grant_vld = 1'b0;
      end
      default: begin
        if (req0)        grant = 2'd0;
        else if (req1)   grant = 2'd1;
        else if (mb_req) grant = 2'd2;
        else             grant_vld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 2'd2;
      owner       <= 1'b0;
      start_cnt   <= '0;
      done_d      <= 1'b0;
      eth_start   <= 1'b0;
      eth_addr    <= '0;
      eth_size    <= '0;
      eth_ram_sel <= 1'b0;
      mb_gnt      <= 1'b0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      busy        <= 1'b0;
`ifdef ETH_SCHED_TIMEOUT_EN
      to_cnt      <= '0;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
`endif
    end else begin
      done_d   <= eth_done;
      // NOTE: non-blocking defaults here make the ack/err strobes one-cycle pulses;
      // a later assignment in the same cycle overrides them.
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
`ifdef ETH_SCHED_TIMEOUT_EN
      req0_err <= 1'b0;
      req1_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant_vld) begin
            ptr  <= grant;
            busy <= 1'b1;
            if (grant == 2'd2) begin
              state       <= CPU;
              mb_gnt      <= 1'b1;
              eth_ram_sel <= 1'b1;
            end else begin
              state     <= START;
              owner     <= grant[0];
              start_cnt <= '0;
              eth_start <= 1'b1;
              eth_addr  <= grant[0] ? req1_addr : req0_addr;
              eth_size  <= grant[0] ? req1_size : req0_size;
            end
          end
        end

        START: begin
          if (start_cnt == 4'(START_LEN - 1)) begin
            eth_start <= 1'b0;
            state     <= WAIT;
`ifdef ETH_SCHED_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end else begin
            start_cnt <= start_cnt + 4'd1;
          end
        end

        // A done level already high on entry has done_d set, so it cannot look like an edge.
        WAIT: begin
          if (done_rise) begin
            state    <= ACK;
            req0_ack <= ~owner;
            req1_ack <= owner;
          end
`ifdef ETH_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            state    <= ACK;
            req0_ack <= ~owner;
            req1_ack <= owner;
            req0_err <= ~owner;
            req1_err <= owner;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end

        ACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        CPU: begin
          if (!mb_req) begin
            state       <= IDLE;
            mb_gnt      <= 1'b0;
            eth_ram_sel <= 1'b0;
            busy        <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_task_sched.sv
// tb_eth_task_sched: directed and randomized checks of eth_task_sched against a
// transaction-level model (round-robin service order, start length, done/timeout latency).
module tb_eth_task_sched;
  localparam int START_LEN = 6;
  localparam int TIMEOUT   = 100;
  localparam int ADDR_W    = 24;
  localparam int SIZE_W    = 13;
`ifdef ETH_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              mclk = 1'b0;
  logic              reset = 1'b1;
  logic              req0 = 1'b0;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [SIZE_W-1:0] req0_size = '0;
  logic              req1 = 1'b0;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [SIZE_W-1:0] req1_size = '0;
  logic              mb_req = 1'b0;
  logic              eth_done = 1'b0;
  logic              req0_ack, req0_err, req1_ack, req1_err;
  logic              mb_gnt, eth_start, eth_ram_sel, busy;
  logic [ADDR_W-1:0] eth_addr;
  logic [SIZE_W-1:0] eth_size;

  eth_task_sched #(
    .START_LEN(START_LEN), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)
  ) dut (
    .mclk(mclk), .reset(reset),
    .req0(req0), .req0_addr(req0_addr), .req0_size(req0_size), .req0_ack(req0_ack), .req0_err(req0_err),
    .req1(req1), .req1_addr(req1_addr), .req1_size(req1_size), .req1_ack(req1_ack), .req1_err(req1_err),
    .mb_req(mb_req), .mb_gnt(mb_gnt), .eth_start(eth_start), .eth_addr(eth_addr), .eth_size(eth_size),
    .eth_ram_sel(eth_ram_sel), .eth_done(eth_done), .busy(busy)
  );

  always #10 mclk = ~mclk;

  int checks    = 0;
  int failures  = 0;
  int excl_viol = 0;
  int gnt_viol  = 0;
  int ack0_cnt  = 0;
  int ack1_cnt  = 0;
  int m_ptr     = 2;   // model: last served source

  logic [63:0] all_out;
  assign all_out = 64'({req0_ack, req0_err, req1_ack, req1_err, mb_gnt, eth_start,
                        eth_ram_sel, busy, eth_addr, eth_size});

  always @(negedge mclk) begin
    if (eth_start && eth_ram_sel) excl_viol++;
    if (mb_gnt !== eth_ram_sel) gnt_viol++;
    if (req0_ack) ack0_cnt++;
    if (req1_ack) ack1_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(120, 160));
    return int'($urandom_range(0, 40));
  endfunction

  // Serve one SPI transaction already requested; d = cycles after WAIT entry before eth_done rises.
  task automatic serve_spi(input int src, input logic [ADDR_W-1:0] ea,
                           input logic [SIZE_W-1:0] es, input int d);
    int lat = 0;
    int n   = 0;
    int a;
    bit exp_err;
    bit bad = 1'b0;
    while (!eth_start && lat < 10) begin tick(); lat++; end
    check("start_latency", 64'(lat), 64'd1);
    check("eth_addr", 64'(eth_addr), 64'(ea));
    check("eth_size", 64'(eth_size), 64'(es));
    while (eth_start && n < 40) begin tick(); n++; end
    check("start_len", 64'(n), 64'(START_LEN));
    exp_err = TO_EN && (d >= TIMEOUT);
    a = exp_err ? TIMEOUT : d + 1;
    for (int i = 0; i < a; i++) begin
      if (i == d) eth_done = 1'b1;
      if (req0_ack || req1_ack || !busy) bad = 1'b1;
      tick();
    end
    check("wait_quiet", 64'(bad), 64'd0);
    check("ack_src", 64'({req1_ack, req0_ack}), (src == 0) ? 64'd1 : 64'd2);
    check("ack_err", 64'({req1_err, req0_err}), exp_err ? ((src == 0) ? 64'd1 : 64'd2) : 64'd0);
    eth_done = 1'b0;
    if (src == 0) req0 = 1'b0;
    else          req1 = 1'b0;
    tick();
    check("ack_pulse", 64'({req1_ack, req0_ack}), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic spi_one(input int src, input logic [ADDR_W-1:0] ea,
                         input logic [SIZE_W-1:0] es, input int d);
    if (src == 0) begin req0 = 1'b1; req0_addr = ea; req0_size = es; end
    else          begin req1 = 1'b1; req1_addr = ea; req1_size = es; end
    m_ptr = src;
    serve_spi(src, ea, es, d);
  endtask

  task automatic serve_cpu(input int hold);
    int lat = 0;
    bit bad = 1'b0;
    while (!mb_gnt && lat < 10) begin tick(); lat++; end
    check("cpu_latency", 64'(lat), 64'd1);
    check("cpu_owns", 64'({eth_ram_sel, busy}), 64'd3);
    for (int i = 0; i < hold; i++) begin
      if (!mb_gnt || !eth_ram_sel || eth_start) bad = 1'b1;
      tick();
    end
    check("cpu_hold", 64'(bad), 64'd0);
    mb_req = 1'b0;
    tick();
    check("cpu_release", 64'({mb_gnt, eth_ram_sel, busy}), 64'd0);
  endtask

  // Assert the sources in mask together; the model serves them in rotation order after m_ptr.
  task automatic run_round(input logic [2:0] mask);
    int order[$];
    logic [ADDR_W-1:0] a0, a1;
    logic [SIZE_W-1:0] s0, s1;
    a0 = ADDR_W'($urandom);
    a1 = ADDR_W'($urandom);
    if (a1 == a0) a1 = ~a0;
    s0 = SIZE_W'($urandom);
    s1 = SIZE_W'($urandom);
    for (int k = 1; k <= 3; k++)
      if (mask[(m_ptr + k) % 3]) order.push_back((m_ptr + k) % 3);
    if (order.size() > 0) m_ptr = order[$];
    req0 = mask[0]; req0_addr = a0; req0_size = s0;
    req1 = mask[1]; req1_addr = a1; req1_size = s1;
    mb_req = mask[2];
    foreach (order[j]) begin
      case (order[j])
        0:       serve_spi(0, a0, s0, rand_delay());
        1:       serve_spi(1, a1, s1, rand_delay());
        default: serve_cpu(int'($urandom_range(0, 20)));
      endcase
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad;
    int n;
    int saved0, saved1;

    #5;
    check("reset_outputs", all_out, 64'd0);
    @(posedge mclk); #1;
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (all_out != 64'd0) bad = 1'b1;
      tick();
    end
    check("idle_1000", 64'(bad), 64'd0);

    // All three from reset, twice: req0, req1, CPU each time.
    run_round(3'b111);
    run_round(3'b111);

    spi_one(0, 24'haaaa55, 13'd9, 500);

    // CPU window of 40 cycles with req1 arriving mid-window.
    mb_req = 1'b1;
    n = 0;
    while (!mb_gnt && n < 10) begin tick(); n++; end
    check("win_gnt", 64'({mb_gnt, eth_ram_sel}), 64'd3);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) begin req1 = 1'b1; req1_addr = 24'haaaa50; req1_size = 13'd17; end
      if (!eth_ram_sel || eth_start) bad = 1'b1;
      tick();
    end
    check("win_hold", 64'(bad), 64'd0);
    mb_req = 1'b0;
    tick();
    check("win_release", 64'({eth_ram_sel, eth_start}), 64'd0);
    m_ptr = 1;
    serve_spi(1, 24'haaaa50, 13'd17, 12);

    // eth_done already high on WAIT entry must be ignored until it falls and rises.
    req0 = 1'b1; req0_addr = 24'h123456; req0_size = 13'd3; m_ptr = 0;
    n = 0;
    while (!eth_start && n < 10) begin tick(); n++; end
    check("lvl_start", 64'(eth_start), 64'd1);
    tick(); tick();
    eth_done = 1'b1;
    n = 0;
    while (eth_start && n < 40) begin tick(); n++; end
    bad = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) eth_done = 1'b0;
      if (req0_ack || !busy) bad = 1'b1;
      tick();
    end
    check("lvl_ignored", 64'(bad), 64'd0);
    eth_done = 1'b1;
    tick();
    check("lvl_ack", 64'({req1_ack, req0_ack, req0_err}), 64'd2);
    eth_done = 1'b0; req0 = 1'b0;
    tick();
    check("lvl_idle", 64'(busy), 64'd0);

    // eth_done never arrives within 300 cycles: times out only when the counter is built.
    spi_one(1, 24'h0f0f0f, 13'd100, 300);

    // Reset in the middle of WAIT.
    req0 = 1'b1; req0_addr = 24'h777777; req0_size = 13'd5;
    n = 0;
    while (!eth_start && n < 10) begin tick(); n++; end
    n = 0;
    while (eth_start && n < 40) begin tick(); n++; end
    repeat (5) tick();
    saved0 = ack0_cnt;
    saved1 = ack1_cnt;
    reset = 1'b1;
    #1;
    check("reset_async", all_out, 64'd0);
    req0 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_ptr = 2;
    repeat (20) tick();
    check("reset_no_ack", 64'((ack0_cnt - saved0) + (ack1_cnt - saved1)), 64'd0);
    check("reset_idle", all_out, 64'd0);
    spi_one(0, 24'h13579b, 13'd42, rand_delay());

    for (int r = 0; r < 30; r++) run_round(3'($urandom_range(1, 7)));

    check("start_ram_sel_exclusive", 64'(excl_viol), 64'd0);
    check("gnt_eq_ram_sel", 64'(gnt_viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_task_sched.md
Name: eth_task_sched

Overview:
- Controller and arbiter in front of eth_task, the SPI master to the Ethernet chip.
- Shares the single eth_task engine between two SPI requesters (req0 = TX push, req1 = RX poll) and the CPU's direct access to the eth_task buffer RAM (mb_* port).
- Sequences each SPI transaction: latches address/size, drives a fixed-length eth_start pulse, waits for eth_done, then acknowledges the requester.
- Drives eth_ram_sel so the CPU owns the buffer RAM only when no SPI transaction is in flight.

Parameters:
- START_LEN, 6, number of mclk cycles eth_start is held high per transaction (1..15).
- TIMEOUT, 65535, mclk cycles to wait for eth_done before aborting (16-bit counter).
- ADDR_W, 24, width of the SPI address/control phase.
- SIZE_W, 13, width of the transfer size field.

Ports:
- mclk  in  1  system clock, 50 MHz.
- reset  in  1  reset.
- req0  in  1  requester 0 transaction request, level, held until req0_ack.
- req0_addr  in  ADDR_W  requester 0 address/control word.
- req0_size  in  SIZE_W  requester 0 transfer size.
- req0_ack  out  1  one-cycle completion pulse to requester 0.
- req0_err  out  1  one-cycle timeout flag, coincident with req0_ack.
- req1, req1_addr, req1_size, req1_ack, req1_err  same as requester 0.
- mb_req  in  1  CPU request for buffer RAM ownership, level.
- mb_gnt  out  1  CPU owns the buffer RAM.
- eth_start  out  1  start strobe to eth_task.
- eth_addr  out  ADDR_W  latched address to eth_task.
- eth_size  out  SIZE_W  latched size to eth_task.
- eth_ram_sel  out  1  1 = CPU side of the buffer RAM selected.
- eth_done  in  1  eth_task completion (level or pulse).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock is mclk. reset is asynchronous and active-high.
- Reset values: all outputs 0. State is IDLE, round-robin pointer is 2 (CPU last served), counters are 0. Asserting reset mid-transaction returns to IDLE immediately and issues no ack.
- The FSM states are IDLE, START, WAIT, ACK and CPU.
- IDLE arbitration:
  - Sources are 0 = req0, 1 = req1, 2 = mb_req.
  - Grant goes to the first asserted source after the pointer, in order 0, 1, 2, wrapping.
  - The pointer updates to the granted source.
  - Arbitration takes one cycle; grant is registered.
- Grant to source 0 or 1:
  - Latch reqN_addr into eth_addr and reqN_size into eth_size in the grant cycle. They are held stable until the next grant.
  - Go to START.
- START: eth_start=1 for exactly START_LEN cycles, then WAIT. The timeout counter clears on entry to WAIT.
- WAIT:
  - eth_done is detected on its rising edge (registered 1d delay).
  - An eth_done level that is already high on entry to WAIT is ignored until it falls and rises again.
  - On the rising edge, go to ACK with err=0.
  - On counter == TIMEOUT-1, go to ACK with err=1.
- ACK: reqN_ack=1 for one cycle, reqN_err=err. Then go to IDLE.
  - If the requester dropped reqN early, the transaction still completes and the ack still pulses.
- Grant to source 2: go to CPU.
  - eth_ram_sel=1 and mb_gnt=1 in the cycle after grant, held while mb_req=1.
  - When mb_req falls, eth_ram_sel and mb_gnt drop next cycle, then IDLE.
  - SPI requests arriving in CPU state wait.
- A reqN still high in the cycle after its ack is treated as a new request and arbitrated normally. No extra gap is required beyond the IDLE cycle.
- eth_ram_sel and eth_start are never both 1.
- Minimum SPI transaction: START_LEN + 3 cycles plus the eth_done latency.

Optional Feature:
- ETH_SCHED_TIMEOUT_EN defined: TIMEOUT counter active; err reported as above.
- ETH_SCHED_TIMEOUT_EN undefined: no counter; WAIT exits only on an eth_done rising edge; req0_err and req1_err are tied 0.

Test Plan:
- reset release, no requests -> all outputs 0, busy=0 for 1000 cycles.
- req0 with addr=24'haaaa55 and size=13'd9; eth_done pulse 500 cycles after eth_start falls -> eth_start high exactly 6 cycles, eth_addr=aaaa55, eth_size=9, req0_ack one cycle with err=0, busy=0 afterwards.
- req0, req1 and mb_req asserted together from reset -> grant order req0, req1, CPU. Then re-asserting all three repeats the order req0, req1, CPU.
- mb_req held 40 cycles while req1 is asserted mid-window -> eth_ram_sel=1 for the whole window, eth_start stays 0 until one cycle after eth_ram_sel drops, and req1 is then served with addr 24'haaaa50.
- With ETH_SCHED_TIMEOUT_EN and TIMEOUT=100, eth_done never asserted -> req1_ack and req1_err both pulse 100 cycles after WAIT entry. Without the macro, the FSM stays in WAIT.
- reset asserted mid-WAIT, then released -> no ack, state IDLE, and the next req0 is served normally.
